// File: rtl/drowsy_decision_pkg.sv
// Shared types and constants for the drowsiness decision stage.
package drowsy_pkg;

  localparam int SCORE_W_DEF     = 10;
  localparam int NUM_CLASSES_DEF = 3;

  localparam int CLS_AWAKE       = 0;
  localparam int CLS_DROWSY      = 1;
  localparam int CLS_EYES_CLOSED = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  typedef logic [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/drowsy_decision_if.sv
// Frame-in / decision-out bundle between the neuron layer, this stage and the alert logic.
interface drowsy_decision_if #(
  parameter int NUM_CLASSES = 3,
  parameter int SCORE_W     = 10,
  parameter int STREAK_W    = 4
);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic               inValid;
  logic [SCORE_W-1:0] inVal [NUM_CLASSES];
  logic               inReady;
  logic               outValid;
  logic [IDX_W-1:0]   classIdx;
  logic [STREAK_W-1:0] streak;
  logic               alarm;
  logic               lowConf;

  modport master (
    output inValid, inVal,
    input  inReady, outValid, classIdx, streak, alarm, lowConf
  );

  modport slave (
    input  inValid, inVal,
    output inReady, outValid, classIdx, streak, alarm, lowConf
  );
endinterface

// File: rtl/drowsy_decision_streak_ctr.sv
// Saturating consecutive-drowsy counter with debounced alarm set/clear.
module drowsy_streak_ctr #(
  parameter int STREAK_W     = 4,
  parameter int ALARM_FRAMES = 4
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                en,
  input  logic                drowsy,
  input  logic                hold,
  output logic [STREAK_W-1:0] streak,
  output logic                alarm
);
  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};
  localparam logic [STREAK_W-1:0] ALARM_THR  = STREAK_W'(ALARM_FRAMES);

  logic [STREAK_W-1:0] streakR;
  logic                alarmR;
  logic [STREAK_W-1:0] nextStreak;

  // Next streak value for a decided frame.
  always_comb begin
    nextStreak = streakR;
    if (!drowsy) begin
      nextStreak = '0;
    end else if (streakR != STREAK_MAX) begin
      nextStreak = streakR + STREAK_W'(1);
    end else begin
      nextStreak = streakR;
    end
  end

  // Alarm rises at the threshold, falls only once the streak is broken.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      streakR <= '0;
      alarmR  <= 1'b0;
    end else if (en && !hold) begin
      streakR <= nextStreak;
      if (nextStreak >= ALARM_THR) begin
        alarmR <= 1'b1;
      end else if (nextStreak == '0) begin
        alarmR <= 1'b0;
      end else begin
        alarmR <= alarmR;
      end
    end else begin
      streakR <= streakR;
      alarmR  <= alarmR;
    end
  end

  assign streak = streakR;
  assign alarm  = alarmR;
endmodule

// File: rtl/drowsy_decision.sv
// Sequential argmax over one frame of class scores, followed by drowsy-streak debounce.
// Optional build macro DROWSY_CONF_GATE_EN: low-confidence winners leave streak/alarm untouched.
module drowsy_decision
  import drowsy_pkg::*;
#(
  parameter int NUM_CLASSES  = NUM_CLASSES_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int DROWSY_MIN   = CLS_DROWSY,
  parameter int ALARM_FRAMES = 4,
  parameter int STREAK_W     = 4,
  parameter int CONF_MIN     = 256
) (
  input logic Clock,
  input logic Rst,
  drowsy_decision_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] DROWSY_IDX = IDX_W'(DROWSY_MIN);

  state_t             state;
  logic [SCORE_W-1:0] scores [NUM_CLASSES];
  logic [SCORE_W-1:0] best;
  logic [IDX_W-1:0]   bestIdx;
  logic [IDX_W-1:0]   idx;
  logic               inReadyR;
  logic               outValidR;
  logic [IDX_W-1:0]   classIdxR;
  logic               lowConfR;
  logic               lowHit;
  logic               decideEn;
  logic               isDrowsy;

`ifdef DROWSY_CONF_GATE_EN
  assign lowHit = (best < SCORE_W'(CONF_MIN));
`else
  assign lowHit = 1'b0;
`endif

  assign decideEn = (state == DECIDE);
  assign isDrowsy = (bestIdx >= DROWSY_IDX);

  // Capture, scan and decide; a frame in flight is dropped on reset.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state     <= IDLE;
      best      <= '0;
      bestIdx   <= '0;
      idx       <= '0;
      inReadyR  <= 1'b1;
      outValidR <= 1'b0;
      classIdxR <= '0;
      lowConfR  <= 1'b0;
      for (int j = 0; j < NUM_CLASSES; j++) begin
        scores[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          outValidR <= 1'b0;
          if (bus.inValid) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
              scores[j] <= bus.inVal[j];
            end
            best     <= bus.inVal[0];
            bestIdx  <= '0;
            idx      <= IDX_W'(1);
            inReadyR <= 1'b0;
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (scores[idx] > best) begin
            best    <= scores[idx];
            bestIdx <= idx;
          end else begin
            best    <= best;
            bestIdx <= bestIdx;
          end
          if (idx == LAST_IDX) begin
            state <= DECIDE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= SCAN;
          end
        end
        DECIDE: begin
          classIdxR <= bestIdx;
          lowConfR  <= lowHit;
          outValidR <= 1'b1;
          inReadyR  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          inReadyR  <= 1'b1;
          outValidR <= 1'b0;
        end
      endcase
    end
  end

  drowsy_streak_ctr #(
    .STREAK_W     (STREAK_W),
    .ALARM_FRAMES (ALARM_FRAMES)
  ) u_streak (
    .Clock  (Clock),
    .Rst    (Rst),
    .en     (decideEn),
    .drowsy (isDrowsy),
    .hold   (lowHit),
    .streak (bus.streak),
    .alarm  (bus.alarm)
  );

  assign bus.inReady  = inReadyR;
  assign bus.outValid = outValidR;
  assign bus.classIdx = classIdxR;
  assign bus.lowConf  = lowConfR;
endmodule

// File: tb/tb_drowsy_decision.sv
// Directed plus randomized self-checking bench for drowsy_decision against a frame-level model.
module tb_drowsy_decision;
  import drowsy_pkg::*;

`ifdef DROWSY_CONF_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif
  localparam int NC        = 3;
  localparam int SW        = 10;
  localparam int STW       = 4;
  localparam int ALARM_N   = 4;
  localparam int SAT_MAX   = 15;
  localparam int CONF_THR  = 256;

  logic Clock = 1'b0;
  logic Rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Frame-level reference state
  int mStreak = 0;
  int mAlarm  = 0;
  int mClass  = 0;
  int mLow    = 0;

  drowsy_decision_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .STREAK_W(STW)) bus ();

  drowsy_decision #(
    .NUM_CLASSES(NC), .SCORE_W(SW), .DROWSY_MIN(1),
    .ALARM_FRAMES(ALARM_N), .STREAK_W(STW), .CONF_MIN(CONF_THR)
  ) dut (
    .Clock (Clock),
    .Rst   (Rst),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply the decision rules to one frame of scores.
  task automatic model(input int a, input int b, input int c);
    int v[3];
    int mx;
    int win;
    v[0] = a; v[1] = b; v[2] = c;
    mx = v[0];
    foreach (v[j]) if (v[j] > mx) mx = v[j];
    win = 0;
    for (int j = NC - 1; j >= 0; j--) if (v[j] == mx) win = j;
    mClass = win;
    mLow   = (GATE && mx < CONF_THR) ? 1 : 0;
    if (mLow == 0) begin
      mStreak = (win >= 1) ? ((mStreak < SAT_MAX) ? mStreak + 1 : SAT_MAX) : 0;
      if (mStreak >= ALARM_N) mAlarm = 1;
      else if (mStreak == 0)  mAlarm = 0;
    end
  endtask

  task automatic checkOutputs(input string tag);
    chk({tag, ".cls"},    bus.classIdx, mClass);
    chk({tag, ".streak"}, bus.streak,   mStreak);
    chk({tag, ".alarm"},  bus.alarm,    mAlarm);
    chk({tag, ".low"},    bus.lowConf,  mLow);
  endtask

  task automatic waitReady(input string tag);
    for (int n = 0; n < 20 && bus.inReady !== 1'b1; n++) tick();
    chk({tag, ".ready"}, bus.inReady, 1);
  endtask

  // Present a frame, check handshake timing, then the decision.
  task automatic runFrame(input int a, input int b, input int c, input bit poke, input string tag);
    waitReady(tag);
    bus.inValid  = 1'b1;
    bus.inVal[0] = SW'(a); bus.inVal[1] = SW'(b); bus.inVal[2] = SW'(c);
    tick();
    bus.inValid = 1'b0;
    chk({tag, ".rdyK"}, bus.inReady, 0);
    chk({tag, ".ovK"},  bus.outValid, 0);
    if (poke) begin
      bus.inValid  = 1'b1;
      bus.inVal[0] = 10'd0; bus.inVal[1] = 10'd999; bus.inVal[2] = 10'd0;
    end
    tick();
    chk({tag, ".rdyK1"}, bus.inReady, 0);
    tick();
    bus.inValid = 1'b0;
    chk({tag, ".rdyK2"}, bus.inReady, 0);
    chk({tag, ".ovK2"},  bus.outValid, 0);
    model(a, b, c);
    tick();
    chk({tag, ".ov"},  bus.outValid, 1);
    chk({tag, ".rdy"}, bus.inReady, 1);
    checkOutputs(tag);
  endtask

  initial begin
    bus.inValid  = 1'b1;
    bus.inVal[0] = 10'd0; bus.inVal[1] = 10'd999; bus.inVal[2] = 10'd0;

    // Reset held for two edges with a frame offered
    tick(); tick();
    chk("rst.rdy", bus.inReady, 1);
    chk("rst.ov",  bus.outValid, 0);
    checkOutputs("rst");
    bus.inValid = 1'b0;
    Rst = 1'b0;
    tick();
    chk("rst.nocap", bus.inReady, 1);
    chk("rst.noov",  bus.outValid, 0);

    runFrame(100, 700, 300, 1'b0, "single");
    tick();
    chk("single.ovclr", bus.outValid, 0);
    checkOutputs("single.hold");

    runFrame(500, 500, 200, 1'b0, "tie");
    tick();

    for (int n = 0; n < 4; n++) runFrame(0, 0, 900, 1'b0, $sformatf("deb%0d", n));
    runFrame(900, 0, 0, 1'b0, "clear");

    for (int n = 0; n < 17; n++) runFrame(0, 999, 0, 1'b0, $sformatf("sat%0d", n));
    runFrame(900, 0, 0, 1'b0, "satclr");

    runFrame(600, 0, 200, 1'b1, "busy");

    // Reset mid-scan drops the frame
    runFrame(0, 800, 0, 1'b0, "prerst");
    waitReady("midrst");
    bus.inValid  = 1'b1;
    bus.inVal[0] = 10'd0; bus.inVal[1] = 10'd0; bus.inVal[2] = 10'd900;
    tick();
    bus.inValid = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    mStreak = 0; mAlarm = 0; mClass = 0; mLow = 0;
    chk("midrst.rdy", bus.inReady, 1);
    chk("midrst.ov",  bus.outValid, 0);
    checkOutputs("midrst");
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("midrst.noov%0d", n), bus.outValid, 0);
    end

    // Confidence gate scenario
    runFrame(900, 0, 0, 1'b0, "cg0");
    runFrame(0, 900, 0, 1'b0, "cg1");
    runFrame(0, 900, 0, 1'b0, "cg2");
    runFrame(100, 200, 150, 1'b0, "cglow");
    runFrame(0, 300, 0, 1'b0, "cgok");

    // Randomized frames, some drawn from a tiny range to force ties
    for (int n = 0; n < 40; n++) begin
      int hi;
      hi = ($urandom_range(0, 2) == 0) ? 3 : 1023;
      runFrame($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
